// File: rtl/user_seq_builder_pkg.sv
// rtl/user_seq_builder_pkg.sv - shared widths, FSM encoding and button codes for user_seq_builder
package user_seq_builder_pkg;

    localparam int N_KEYS  = 4;
    localparam int MAX_ENT = 16;
    localparam int SEQ_W   = N_KEYS * MAX_ENT;
    localparam int CNT_W   = 5;

    localparam logic [1:0] ST_IDLE         = 2'b00;
    localparam logic [1:0] ST_WAIT_PRESS   = 2'b01;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'b10;
    localparam logic [1:0] ST_DONE         = 2'b11;

    typedef logic [N_KEYS-1:0] key_t;

    localparam key_t KEY0 = 4'b0001;
    localparam key_t KEY1 = 4'b0010;
    localparam key_t KEY2 = 4'b0100;
    localparam key_t KEY3 = 4'b1000;

    function automatic logic is_valid_key(input key_t k);
        return (k == KEY0) || (k == KEY1) || (k == KEY2) || (k == KEY3);
    endfunction

endpackage

// File: rtl/user_seq_builder_key_sync_debounce.sv
// rtl/user_seq_builder_key_sync_debounce.sv - 2-flop button synchronizer; stability counter under USER_SEQ_DEBOUNCE_EN
module key_sync_debounce
    import user_seq_builder_pkg::*;
#(
    parameter int W = N_KEYS
`ifdef USER_SEQ_DEBOUNCE_EN
    ,
    parameter int DEB_CYCLES = 50000
`endif
) (
    input  logic         clk,
    input  logic         R,
    input  logic [W-1:0] key_in,
    output logic [W-1:0] ks
);

    logic [W-1:0] s1_q, s1_d;
    logic [W-1:0] s2_q, s2_d;

    always_comb begin
        s1_d = key_in;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

`ifdef USER_SEQ_DEBOUNCE_EN
    localparam int DCW = $clog2(DEB_CYCLES + 1);

    logic [DCW-1:0] deb_cnt_q, deb_cnt_d;
    logic [W-1:0]   cand_q, cand_d;
    logic [W-1:0]   ks_q, ks_d;

    // cand_q trails the synchronized value; any difference restarts the stability count
    always_comb begin
        cand_d    = s2_q;
        deb_cnt_d = deb_cnt_q;
        ks_d      = ks_q;
        if (s2_q != cand_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q != DCW'(DEB_CYCLES)) begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
        if (deb_cnt_q == DCW'(DEB_CYCLES)) begin
            ks_d = cand_q;
        end
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            deb_cnt_q <= '0;
            cand_q    <= '0;
            ks_q      <= '0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            cand_q    <= cand_d;
            ks_q      <= ks_d;
        end
    end

    assign ks = ks_q;
`else
    assign ks = s2_q;
`endif

endmodule

// File: rtl/user_seq_builder.sv
// rtl/user_seq_builder.sv - assembles one-hot button presses into the 64-bit user sequence word
// Optional debounce qualification compiled in with USER_SEQ_DEBOUNCE_EN.
module user_seq_builder
    import user_seq_builder_pkg::*;
`ifdef USER_SEQ_DEBOUNCE_EN
#(
    parameter int DEB_CYCLES = 50000
)
`endif
(
    input  logic              clk,
    input  logic              R,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic [N_KEYS-1:0] key,
    output logic [SEQ_W-1:0]  data,
    output logic              E,
    output logic              busy,
    output logic [CNT_W-1:0]  cnt,
    output logic              err
);

    logic [N_KEYS-1:0] ks;

`ifdef USER_SEQ_DEBOUNCE_EN
    key_sync_debounce #(.W(N_KEYS), .DEB_CYCLES(DEB_CYCLES)) u_sync (
`else
    key_sync_debounce #(.W(N_KEYS)) u_sync (
`endif
        .clk    (clk),
        .R      (R),
        .key_in (key),
        .ks     (ks)
    );

    logic [1:0]       state_q, state_d;
    logic [SEQ_W-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] len_clamped;
    logic [CNT_W-1:0] cnt_inc;

    assign len_clamped = (len > CNT_W'(MAX_ENT)) ? CNT_W'(MAX_ENT) : len;
    assign cnt_inc     = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        err_d   = 1'b0;
        // start restarts from any state except DONE, whose load pulse must not be lost
        if (start && (state_q != ST_DONE)) begin
            data_d  = '0;
            cnt_d   = '0;
            len_d   = len_clamped;
            state_d = (len_clamped == '0) ? ST_DONE : ST_WAIT_PRESS;
        end else begin
            case (state_q)
                ST_WAIT_PRESS: begin
                    if (ks != '0) begin
                        if (is_valid_key(ks)) begin
                            for (int k = 0; k < MAX_ENT; k++) begin
                                if (cnt_q == CNT_W'(k)) begin
                                    data_d[SEQ_W-1-N_KEYS*k -: N_KEYS] = ks;
                                end
                            end
                            cnt_d   = cnt_inc;
                            state_d = (cnt_inc == len_q) ? ST_DONE : ST_WAIT_RELEASE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_WAIT_RELEASE;
                        end
                    end
                end
                ST_WAIT_RELEASE: begin
                    if (ks == '0) begin
                        state_d = ST_WAIT_PRESS;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    assign data = data_q;
    assign cnt  = cnt_q;
    assign err  = err_q;
    assign E    = (state_q == ST_DONE);
    assign busy = (state_q == ST_WAIT_PRESS) || (state_q == ST_WAIT_RELEASE);

endmodule

// File: tb/tb_user_seq_builder.sv
// tb/tb_user_seq_builder.sv - scoreboard bench for user_seq_builder with directed press sequences
module tb_user_seq_builder;
    import user_seq_builder_pkg::*;

    logic        clk = 1'b0;
    logic        R = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  len = '0;
    logic [3:0]  key = '0;
    logic [63:0] data;
    logic        E;
    logic        busy;
    logic [4:0]  cnt;
    logic        err;

    user_seq_builder dut (
        .clk   (clk),
        .R     (R),
        .start (start),
        .len   (len),
        .key   (key),
        .data  (data),
        .E     (E),
        .busy  (busy),
        .cnt   (cnt),
        .err   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic [4:0]  c;
    } exp_t;

    exp_t exp_q[$];
    logic [4:0] err_exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] d, input logic [4:0] c);
        exp_t e;
        e.d = d;
        e.c = c;
        exp_q.push_back(e);
    endtask

    // Monitor: every load or error pulse must match an outstanding expectation
    always @(negedge clk) begin
        if (!R) begin
            if (E) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_E", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("E_data", data, e.d);
                    chk("E_cnt", 64'(cnt), 64'(e.c));
                    chk("E_busy", 64'(busy), 64'd0);
                end
            end
            if (err) begin
                if (err_exp_q.size() == 0) begin
                    chk("unexpected_err", 64'd1, 64'd0);
                end else begin
                    logic [4:0] ec;
                    ec = err_exp_q.pop_front();
                    chk("err_cnt", 64'(cnt), 64'(ec));
                end
            end
        end
    end

    task automatic start_round(input logic [4:0] l);
        start = 1'b1;
        len = l;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic press(input logic [3:0] k, input int hold);
        key = k;
        repeat (hold) @(posedge clk);
        #1;
        key = '0;
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (((exp_q.size() != 0) || (err_exp_q.size() != 0)) && (t < 200)) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (t >= 200) chk("drain_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", data, 64'd0);
        chk("rst_E", 64'(E), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cnt", 64'(cnt), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        @(posedge clk);
        #1;
        R = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-round after three captured entries
        start_round(5'd4);
        press(KEY0, 5);
        press(KEY1, 5);
        press(KEY2, 5);
        chk("pre_rst_cnt", 64'(cnt), 64'd3);
        chk("pre_rst_data", data, 64'h1240_0000_0000_0000);
        R = 1'b1;
        #1;
        chk("mid_rst_data", data, 64'd0);
        chk("mid_rst_cnt", 64'(cnt), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        R = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // len=3 with load latency check on the final press
        push_exp(64'h1480_0000_0000_0000, 5'd3);
        start_round(5'd3);
        press(KEY0, 10);
        press(KEY2, 10);
        key = KEY3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("lat_E_early", 64'(E), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_E_on_time", 64'(E), 64'd1);
        repeat (8) @(posedge clk);
        #1;
        key = '0;
        wait_drain();
        chk("len3_busy", 64'(busy), 64'd0);
        chk("len3_cnt", 64'(cnt), 64'd3);
        repeat (10) @(posedge clk);
        #1;

        // len=16 alternating buttons
        push_exp(64'h2121_2121_2121_2121, 5'd16);
        start_round(5'd16);
        for (int i = 0; i < 16; i++) press(((i % 2) == 0) ? KEY1 : KEY0, 5);
        wait_drain();
        chk("len16_cnt", 64'(cnt), 64'd16);

        // len=2 with a rejected multi-key press
        err_exp_q.push_back(5'd0);
        push_exp(64'h2100_0000_0000_0000, 5'd2);
        start_round(5'd2);
        press(4'b0011, 5);
        press(KEY1, 5);
        press(KEY0, 5);
        wait_drain();
        chk("len2_cnt", 64'(cnt), 64'd2);

        // len=4, one long hold counts once; restart mid-round clears the word
        start_round(5'd4);
        key = KEY2;
        repeat (200) @(posedge clk);
        #1;
        chk("hold_cnt", 64'(cnt), 64'd1);
        chk("hold_busy", 64'(busy), 64'd1);
        key = '0;
        repeat (5) @(posedge clk);
        #1;
        start_round(5'd4);
        @(negedge clk);
        chk("restart_data", data, 64'd0);
        chk("restart_cnt", 64'(cnt), 64'd0);
        chk("restart_busy", 64'(busy), 64'd1);
        repeat (20) @(posedge clk);
        #1;

        // len=0 loads an empty word one cycle after start
        push_exp(64'd0, 5'd0);
        start_round(5'd0);
        @(negedge clk);
        chk("len0_E", 64'(E), 64'd1);
        wait_drain();
        repeat (3) @(posedge clk);
        #1;

        // len=20 clamps to 16
        push_exp(64'h8888_8888_8888_8888, 5'd16);
        start_round(5'd20);
        for (int i = 0; i < 16; i++) press(KEY3, 5);
        wait_drain();
        chk("len20_cnt", 64'(cnt), 64'd16);

        // Presses in IDLE are ignored
        press(KEY0, 5);
        chk("idle_press_data", data, 64'h8888_8888_8888_8888);
        repeat (5) @(posedge clk);
        #1;
        chk("final_queue", 64'(exp_q.size() + err_exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
